// File: rtl/adc_access_arbiter_if.sv
// adc_access_arbiter_if
//   Bundles the requester-side and SPI-reader-side signals of the ADC access
//   arbiter.
//   master : environment side (requesters + SPI reader); drives req, spi_done, spi_data
//   slave  : arbiter side; drives rsp_valid, rsp_data, rsp_err, grant_id, busy, spi_start
//   NREQ must match the NREQ of the arbiter instance bound to this interface.
interface adc_access_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req;        // per-requester level request
  logic [NREQ-1:0] rsp_valid;  // one-hot response pulse
  logic [11:0]     rsp_data;   // conversion result
  logic            rsp_err;    // timeout flag, with rsp_valid
  logic [2:0]      grant_id;   // current/last granted requester
  logic            busy;       // conversion or recovery in progress
  logic            spi_start;  // pulse to SPI reader
  logic            spi_done;   // pulse from SPI reader
  logic [11:0]     spi_data;   // SPI reader word

  modport master (
    output req, spi_done, spi_data,
    input  rsp_valid, rsp_data, rsp_err, grant_id, busy, spi_start
  );

  modport slave (
    input  req, spi_done, spi_data,
    output rsp_valid, rsp_data, rsp_err, grant_id, busy, spi_start
  );
endinterface

// File: rtl/adc_access_arbiter.sv
// adc_access_arbiter
//   Shares one 12-bit SPI ADC reader among NREQ requesters. Round-robin grant,
//   one conversion at a time: pulse spi_start, wait for spi_done (or abort on
//   timeout), return the word to the granted requester, then hold off MIN_GAP
//   cycles so CS can recover before the next conversion.
// Ports
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : adc_access_arbiter_if.slave -- req/rsp_* toward requesters,
//          spi_start/spi_done/spi_data toward the SPI reader, grant_id/busy status
// Parameters
//   NREQ    (2..8) number of requesters
//   MIN_GAP (>=1)  idle cycles between conversions
//   TIMEOUT (>=2)  BUSY cycles allowed before the conversion is aborted
module adc_access_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MIN_GAP = 100,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                 clk,
  input logic                 rst,
  adc_access_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      last_grant_q, last_grant_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [11:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            spi_start_q, spi_start_d;

  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [7:0]      grant_onehot;

  // Round-robin pick: scan last_grant+1, +2, ... wrapping, last_grant itself last.
  always_comb begin
    logic [7:0]  req_ext;
    logic [2:0]  cand;
    int unsigned cand_i;
    req_ext              = '0;
    req_ext[NREQ-1:0]    = bus.req;
    cand                 = '0;
    cand_i               = 0;
    pick_found           = 1'b0;
    pick_idx             = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_i = (32'(last_grant_q) + i) % NREQ;
      cand   = cand_i[2:0];
      if (!pick_found && req_ext[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_onehot = 8'd1 << grant_id_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          state_d      = S_START;
        end
      end
      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        // spi_done has priority over a timeout landing in the same cycle.
        if (bus.spi_done) begin
          rsp_data_d  = bus.spi_data;
          rsp_valid_d = grant_onehot[NREQ-1:0];
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_onehot[NREQ-1:0];
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(MIN_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    spi_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'(NREQ - 1);
      grant_id_q   <= '0;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      spi_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      spi_start_q  <= spi_start_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.spi_start = spi_start_q;

endmodule

// File: tb/tb_adc_access_arbiter.sv
// tb_adc_access_arbiter
//   Directed bench for adc_access_arbiter with NREQ=4, MIN_GAP=4, TIMEOUT=64.
//   Each table row is one conversion: request pattern, SPI answer delay/word,
//   and the hand-computed grant, response and timing expected for it.
module tb_adc_access_arbiter;

  localparam int NREQ    = 4;
  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 64;
  localparam logic [11:0] JUNK = 12'h5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_rsp_cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  adc_access_arbiter_if #(.NREQ(NREQ)) bus ();

  adc_access_arbiter #(
    .NREQ   (NREQ),
    .MIN_GAP(MIN_GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          pre_rst;
    logic [3:0]  req;
    int          delay;      // cycles after spi_start to pulse spi_done; 0 = never
    logic [11:0] data;
    logic [2:0]  exp_grant;
    logic [11:0] exp_data;
    logic        exp_err;
    int          exp_lat;    // spi_start -> rsp_valid cycles
    bit          chk_lat;    // DUT idle: spi_start must follow req by one cycle
    int          exp_gap;    // previous rsp_valid -> spi_start cycles; 0 = skip
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string name);
    check(name, 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.grant_id,
                     bus.busy, bus.spi_start}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.spi_done = 1'b0;
    bus.spi_data = JUNK;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.spi_start) seen = 1'b1;
    end
  endtask

  // Called at the negedge where spi_start is seen; n counts cycles from there.
  task automatic respond(input int delay, input logic [11:0] data, input int drop_at,
                         input logic [3:0] drop_val, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (delay > 0 && n == delay) begin
        bus.spi_done = 1'b1;
        bus.spi_data = data;
      end
      if (n == drop_at) bus.req = drop_val;
      @(negedge clk);
      n++;
      bus.spi_done = 1'b0;
      bus.spi_data = JUNK;
      if (bus.rsp_valid != '0) seen = 1'b1;
    end
  endtask

  task automatic run_row(input int idx);
    vec_t v;
    int   n;
    bit   seen;
    v = vecs[idx];
    if (v.pre_rst) do_reset();
    bus.req = v.req;
    wait_start(n, seen);
    check($sformatf("r%0d_start_seen", idx), 32'(seen), 32'd1);
    if (!seen) return;
    if (v.chk_lat) check($sformatf("r%0d_start_latency", idx), n, 32'd1);
    if (v.exp_gap != 0) check($sformatf("r%0d_start_gap", idx), cyc - last_rsp_cyc, v.exp_gap);
    check($sformatf("r%0d_grant_id", idx), 32'(bus.grant_id), 32'(v.exp_grant));
    respond(v.delay, v.data, -1, 4'b0000, n, seen);
    check($sformatf("r%0d_rsp_seen", idx), 32'(seen), 32'd1);
    if (!seen) return;
    check($sformatf("r%0d_rsp_latency", idx), n, v.exp_lat);
    check($sformatf("r%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'(4'b0001 << v.exp_grant));
    check($sformatf("r%0d_rsp_data", idx), 32'(bus.rsp_data), 32'(v.exp_data));
    check($sformatf("r%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
    last_rsp_cyc = cyc;
    @(negedge clk);
    check($sformatf("r%0d_pulse_end", idx), 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
    check($sformatf("r%0d_data_hold", idx), 32'(bus.rsp_data), 32'(v.exp_data));
    check($sformatf("r%0d_busy_gap", idx), 32'(bus.busy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;

    //          rst req      dly  data     grant exp_data err lat chk gap
    vecs[0]  = '{0, 4'b0001, 20, 12'h3A0, 3'd0, 12'h3A0, 0, 21, 1, 0};
    vecs[1]  = '{0, 4'b0001,  3, 12'h0C5, 3'd0, 12'h0C5, 0,  4, 0, 5};
    vecs[2]  = '{1, 4'b1111,  5, 12'hA00, 3'd0, 12'hA00, 0,  6, 1, 0};
    vecs[3]  = '{0, 4'b1111,  7, 12'hA01, 3'd1, 12'hA01, 0,  8, 0, 5};
    vecs[4]  = '{0, 4'b1111,  2, 12'hA02, 3'd2, 12'hA02, 0,  3, 0, 5};
    vecs[5]  = '{0, 4'b1111,  9, 12'hA03, 3'd3, 12'hA03, 0, 10, 0, 5};
    vecs[6]  = '{0, 4'b1111,  1, 12'hA10, 3'd0, 12'hA10, 0,  2, 0, 5};
    vecs[7]  = '{0, 4'b0100,  0, 12'hFFF, 3'd2, 12'h000, 1, 65, 0, 5};
    vecs[8]  = '{0, 4'b1001,  4, 12'h900, 3'd0, 12'h900, 0,  5, 1, 0};
    vecs[9]  = '{0, 4'b1000,  4, 12'h800, 3'd3, 12'h800, 0,  5, 0, 5};
    vecs[10] = '{0, 4'b0100,  3, 12'h2C2, 3'd2, 12'h2C2, 0,  4, 0, 5};

    bus.req = '0;
    bus.spi_done = 1'b0;
    bus.spi_data = JUNK;
    do_reset();
    check_zero("reset_outputs");

    // Single request, min gap, round robin over all four, timeout.
    for (int i = 0; i <= 7; i++) run_row(i);

    // spi_done pulses in GAP and then IDLE must be ignored.
    bus.req = '0;
    for (int i = 0; i < 8; i++) begin
      bus.spi_done = 1'b1;
      bus.spi_data = 12'h777;
      @(negedge clk);
      check($sformatf("stray_done_%0d", i), 32'({bus.rsp_valid, bus.spi_start}), 32'd0);
    end
    bus.spi_done = 1'b0;
    bus.spi_data = JUNK;
    check("stray_done_idle", 32'(bus.busy), 32'd0);
    check("stray_done_data", 32'(bus.rsp_data), 32'd0);

    // Reset in the middle of BUSY, then a late spi_done.
    bus.req = 4'b0010;
    wait_start(n, seen);
    check("mid_rst_start_seen", 32'(seen), 32'd1);
    check("mid_rst_grant", 32'(bus.grant_id), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check_zero("mid_rst_outputs");
    rst = 1'b0;
    bus.spi_done = 1'b1;
    bus.spi_data = 12'hABC;
    @(negedge clk);
    bus.spi_done = 1'b0;
    bus.spi_data = JUNK;
    for (int i = 0; i < 3; i++) begin
      check_zero($sformatf("late_done_%0d", i));
      @(negedge clk);
    end

    // Priority back to req[0] after reset, then req[3].
    run_row(8);
    run_row(9);

    // req[1] withdrawn two cycles into its conversion; req[2] waits behind it.
    bus.req = 4'b0110;
    wait_start(n, seen);
    check("drop_start_seen", 32'(seen), 32'd1);
    check("drop_start_gap", cyc - last_rsp_cyc, 32'd5);
    check("drop_grant", 32'(bus.grant_id), 32'd1);
    respond(6, 12'h1B1, 2, 4'b0100, n, seen);
    check("drop_rsp_seen", 32'(seen), 32'd1);
    check("drop_rsp_latency", n, 32'd7);
    check("drop_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0010));
    check("drop_rsp_data", 32'(bus.rsp_data), 32'h1B1);
    check("drop_rsp_err", 32'(bus.rsp_err), 32'd0);
    last_rsp_cyc = cyc;
    run_row(10);

    bus.req = '0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
